// File: rtl/usb_frame_parser_if.sv
// Byte-stream and burst bus between the FTDI receiver, the frame parser
// and usb_ctrl_regs. The master drives received bytes in; the slave (the
// parser) drives the validated burst and the status outputs.
interface usb_frame_parser_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] d;
  logic       d_asserted;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] err_cnt;

  modport master (
    output rx_byte, rx_valid,
    input  rx_ready, d, d_asserted, frame_ok, frame_err, err_code, err_cnt
  );

  modport slave (
    input  rx_byte, rx_valid,
    output rx_ready, d, d_asserted, frame_ok, frame_err, err_code, err_cnt
  );
endinterface

// File: rtl/usb_frame_parser.sv
// Framed host-command parser on the clk_ftdi domain. It hunts for the
// 0x5E 0x4D preamble, checks the header (HCS) and payload (DCS) XOR sums,
// buffers the payload and, only for a fully valid frame, replays
// CTRL, ADDR, payload as one contiguous d/d_asserted burst followed by a
// forced idle gap so usb_ctrl_regs can return to its CTRL state.
module usb_frame_parser #(
  parameter int MAX_LEN     = 64,
  parameter int TIMEOUT_CYC = 65535,
  parameter int GAP_CYC     = 2
) (
  input logic             clk_ftdi,
  input logic             n_rst,
  usb_frame_parser_if.slave bus
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [8:0]    MAX_LEN_C  = 9'(MAX_LEN);
  localparam logic [TW-1:0] TMO_C      = TW'(TIMEOUT_CYC);
  localparam logic [GW-1:0] GAP_LAST_C = GW'(GAP_CYC - 1);

  typedef enum logic [3:0] {
    S_HUNT1   = 4'd0,
    S_HUNT2   = 4'd1,
    S_ADDR    = 4'd2,
    S_CTRL    = 4'd3,
    S_LEN     = 4'd4,
    S_HCS     = 4'd5,
    S_PAYLOAD = 4'd6,
    S_DCS     = 4'd7,
    S_REPLAY  = 4'd8,
    S_GAP     = 4'd9
  } state_t;

  // Header checksum: XOR of the three header fields.
  function automatic logic [7:0] hcs_calc(input logic [7:0] a, input logic [7:0] c,
                                          input logic [7:0] l);
    return a ^ c ^ l;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [7:0]    addr_r, ctrl_r, len_r, xor_r;
  logic [7:0]    wr_ptr_r;
  logic [7:0]    pay_buf_r [MAX_LEN];
  logic [7:0]    beat_r;
  logic [TW-1:0] tmo_r;
  logic [GW-1:0] gap_r;

  logic          rx_ready_r, d_asserted_r, frame_ok_r, frame_err_r;
  logic [7:0]    d_r, err_cnt_r;
  logic [1:0]    err_code_r;

  logic          accept_s, tmo_active_s, tmo_drop_s;
  logic          drop_s, burst_start_s, beat_adv_s, burst_end_s;
  logic [1:0]    drop_code_s;
  logic [AW-1:0] wr_idx_s, rd_idx_s;
  logic [7:0]    beat_byte_s;

  assign accept_s     = bus.rx_valid & rx_ready_r;
  assign tmo_active_s = (state_r != S_HUNT1) && (state_r != S_REPLAY) && (state_r != S_GAP);
  // An accepted byte on the expiry cycle wins over the timeout.
  assign tmo_drop_s   = tmo_active_s && !accept_s && (tmo_r == TMO_C);
  assign wr_idx_s     = AW'(wr_ptr_r);

  // Select the byte for the next replay beat: ADDR on beat 1, buffer after.
  always_comb begin
    rd_idx_s = AW'(beat_r - 8'd2);
    if (beat_r == 8'd1) begin
      beat_byte_s = addr_r;
    end else begin
      beat_byte_s = pay_buf_r[rd_idx_s];
    end
  end

  // Next-state decode with drop and burst control strobes.
  always_comb begin
    state_nxt_s   = state_r;
    drop_s        = 1'b0;
    drop_code_s   = 2'd0;
    burst_start_s = 1'b0;
    beat_adv_s    = 1'b0;
    burst_end_s   = 1'b0;
    if (tmo_drop_s) begin
      drop_s      = 1'b1;
      drop_code_s = 2'd0;
      state_nxt_s = S_HUNT1;
    end else begin
      case (state_r)
        S_HUNT1: begin
          if (accept_s && (bus.rx_byte == 8'h5E)) state_nxt_s = S_HUNT2;
          else                                    state_nxt_s = S_HUNT1;
        end
        S_HUNT2: begin
          if (accept_s) begin
            if (bus.rx_byte == 8'h4D)      state_nxt_s = S_ADDR;
            else if (bus.rx_byte == 8'h5E) state_nxt_s = S_HUNT2;
            else                           state_nxt_s = S_HUNT1;
          end else begin
            state_nxt_s = S_HUNT2;
          end
        end
        S_ADDR: begin
          if (accept_s) state_nxt_s = S_CTRL;
          else          state_nxt_s = S_ADDR;
        end
        S_CTRL: begin
          if (accept_s) state_nxt_s = S_LEN;
          else          state_nxt_s = S_CTRL;
        end
        S_LEN: begin
          if (accept_s) state_nxt_s = S_HCS;
          else          state_nxt_s = S_LEN;
        end
        S_HCS: begin
          if (accept_s) begin
            if (bus.rx_byte != hcs_calc(addr_r, ctrl_r, len_r)) begin
              drop_s      = 1'b1;
              drop_code_s = 2'd1;
              state_nxt_s = S_HUNT1;
            end else if ((len_r == 8'd0) || ({1'b0, len_r} > MAX_LEN_C)) begin
              drop_s      = 1'b1;
              drop_code_s = 2'd2;
              state_nxt_s = S_HUNT1;
            end else begin
              state_nxt_s = S_PAYLOAD;
            end
          end else begin
            state_nxt_s = S_HCS;
          end
        end
        S_PAYLOAD: begin
          if (accept_s && ((wr_ptr_r + 8'd1) == len_r)) state_nxt_s = S_DCS;
          else                                          state_nxt_s = S_PAYLOAD;
        end
        S_DCS: begin
          if (accept_s) begin
            if (bus.rx_byte == xor_r) begin
              burst_start_s = 1'b1;
              state_nxt_s   = S_REPLAY;
            end else begin
              drop_s      = 1'b1;
              drop_code_s = 2'd3;
              state_nxt_s = S_HUNT1;
            end
          end else begin
            state_nxt_s = S_DCS;
          end
        end
        S_REPLAY: begin
          if (beat_r == (len_r + 8'd2)) begin
            burst_end_s = 1'b1;
            state_nxt_s = S_GAP;
          end else begin
            beat_adv_s  = 1'b1;
            state_nxt_s = S_REPLAY;
          end
        end
        S_GAP: begin
          if (gap_r == GAP_LAST_C) state_nxt_s = S_HUNT1;
          else                     state_nxt_s = S_GAP;
        end
        default: state_nxt_s = S_HUNT1;
      endcase
    end
  end

  // Header field latches, write pointer and running payload XOR.
  always_ff @(posedge clk_ftdi or negedge n_rst) begin
    if (!n_rst) begin
      addr_r   <= 8'd0;
      ctrl_r   <= 8'd0;
      len_r    <= 8'd0;
      xor_r    <= 8'd0;
      wr_ptr_r <= 8'd0;
    end else if (accept_s) begin
      case (state_r)
        S_ADDR:    addr_r <= bus.rx_byte;
        S_CTRL:    ctrl_r <= bus.rx_byte;
        S_LEN:     len_r  <= bus.rx_byte;
        S_HCS: begin
          wr_ptr_r <= 8'd0;
          xor_r    <= 8'd0;
        end
        S_PAYLOAD: begin
          wr_ptr_r <= wr_ptr_r + 8'd1;
          xor_r    <= xor_r ^ bus.rx_byte;
        end
        default: ;
      endcase
    end
  end

  // Payload storage; stale contents are never replayed, so no reset.
  always_ff @(posedge clk_ftdi) begin
    if (accept_s && (state_r == S_PAYLOAD)) begin
      pay_buf_r[wr_idx_s] <= bus.rx_byte;
    end
  end

  // State register, timers and all registered outputs.
  always_ff @(posedge clk_ftdi or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= S_HUNT1;
      rx_ready_r   <= 1'b1;
      d_r          <= 8'd0;
      d_asserted_r <= 1'b0;
      frame_ok_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      err_code_r   <= 2'd0;
      err_cnt_r    <= 8'd0;
      beat_r       <= 8'd0;
      tmo_r        <= '0;
      gap_r        <= '0;
    end else begin
      state_r     <= state_nxt_s;
      rx_ready_r  <= !((state_nxt_s == S_REPLAY) || (state_nxt_s == S_GAP));
      frame_ok_r  <= burst_end_s;
      frame_err_r <= drop_s;
      if (drop_s) begin
        err_code_r <= drop_code_s;
        if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
      end
      if (burst_start_s) begin
        d_r          <= ctrl_r;
        d_asserted_r <= 1'b1;
        beat_r       <= 8'd1;
      end else if (beat_adv_s) begin
        d_r          <= beat_byte_s;
        d_asserted_r <= 1'b1;
        beat_r       <= beat_r + 8'd1;
      end else begin
        d_r          <= 8'd0;
        d_asserted_r <= 1'b0;
      end
      if (burst_end_s) begin
        gap_r <= '0;
      end else if (state_r == S_GAP) begin
        gap_r <= gap_r + GW'(1);
      end
      if (!tmo_active_s || accept_s || tmo_drop_s) begin
        tmo_r <= '0;
      end else begin
        tmo_r <= tmo_r + TW'(1);
      end
    end
  end

  assign bus.rx_ready   = rx_ready_r;
  assign bus.d          = d_r;
  assign bus.d_asserted = d_asserted_r;
  assign bus.frame_ok   = frame_ok_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.err_code   = err_code_r;
  assign bus.err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_usb_frame_parser.sv
// Directed bench for usb_frame_parser: good frames, each drop cause,
// LEN boundaries, preamble resync, timeout, reset mid-burst and
// back-to-back frames with bytes presented while the parser is busy.
module tb_usb_frame_parser;
  localparam int MAX_LEN = 64, TIMEOUT_CYC = 100, GAP_CYC = 2;
  localparam logic [7:0] GOOD [9] = '{8'h5E, 8'h4D, 8'h08, 8'h00, 8'h02, 8'h0A, 8'h02, 8'h00, 8'h02};
  localparam logic [7:0] GOOD_B [4] = '{8'h00, 8'h08, 8'h02, 8'h00};

  logic clk_ftdi = 1'b0;
  logic n_rst = 1'b0;
  usb_frame_parser_if bus();

  usb_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk_ftdi(clk_ftdi), .n_rst(n_rst), .bus(bus)
  );

  always #5 clk_ftdi = ~clk_ftdi;

  int total = 0, bad = 0, cyc = 0, last_tx_cyc = 0;
  int ok_cnt = 0, errp_cnt = 0, err_cyc = 0, viol = 0, run = 0, low_run = 0;
  logic prev_da = 1'b0;
  logic [7:0] cap_q [$];
  int bstart_q [$];
  int blen_q [$];
  int low_q [$];
  logic [7:0] frm [80];

  always @(posedge clk_ftdi) cyc <= cyc + 1;

  // Burst / pulse monitor sampling on the falling edge.
  always @(negedge clk_ftdi) begin
    prev_da <= bus.d_asserted;
    if (bus.d_asserted) cap_q.push_back(bus.d);
    if (bus.d_asserted && !prev_da) begin
      bstart_q.push_back(cyc);
      run <= 1;
    end else if (bus.d_asserted) begin
      run <= run + 1;
    end else if (prev_da) begin
      blen_q.push_back(run);
    end
    if (bus.frame_ok) ok_cnt <= ok_cnt + 1;
    if (bus.frame_err) begin
      errp_cnt <= errp_cnt + 1;
      err_cyc  <= cyc;
    end
    if (bus.d_asserted && bus.rx_ready) viol <= viol + 1;
    if (!bus.rx_ready) low_run <= low_run + 1;
    else if (low_run != 0) begin
      low_q.push_back(low_run);
      low_run <= 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_ftdi);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    @(posedge clk_ftdi); #1;
    while (!bus.rx_ready && w < 200) begin
      @(posedge clk_ftdi); #1;
      w++;
    end
    if (w >= 200) begin
      total++; bad++;
      $display("FAIL send_wait: rx_ready=%b required 1", bus.rx_ready);
    end
    bus.rx_byte = b; bus.rx_valid = 1'b1; last_tx_cyc = cyc;
    @(posedge clk_ftdi); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(frm[i]);
  endtask

  task automatic drive_raw(input logic [7:0] b);
    @(posedge clk_ftdi); #1;
    bus.rx_byte = b; bus.rx_valid = 1'b1;
    @(posedge clk_ftdi); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic load_good();
    for (int i = 0; i < 9; i++) frm[i] = GOOD[i];
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0; bus.rx_byte = 8'h00; n_rst = 1'b0;
    tick(3);
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
    total++; if (bus.d !== 8'h00) begin bad++; $display("FAIL reset_d: got %h want 00", bus.d); end
    total++; if (bus.d_asserted !== 1'b0) begin bad++; $display("FAIL reset_d_asserted: got %b want 0", bus.d_asserted); end
    total++; if (bus.frame_ok !== 1'b0) begin bad++; $display("FAIL reset_frame_ok: got %b want 0", bus.frame_ok); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    total++; if (bus.err_code !== 2'd0) begin bad++; $display("FAIL reset_err_code: got %0d want 0", bus.err_code); end
    total++; if (bus.err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); end
    @(negedge clk_ftdi); n_rst = 1'b1;
    tick(2);
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL post_reset_rx_ready: got %b want 1", bus.rx_ready); end
  endtask

  task automatic test_good_frame();
    int b0, s0, k0, e0;
    logic [7:0] got;
    b0 = cap_q.size(); s0 = bstart_q.size(); k0 = ok_cnt; e0 = errp_cnt;
    load_good(); send_range(0, 8); tick(10);
    total++; if (bstart_q.size() - s0 != 1) begin bad++; $display("FAIL good_burst_count: got %0d want 1", bstart_q.size() - s0); end
    if (bstart_q.size() > s0) begin
      total++; if (bstart_q[s0] - last_tx_cyc != 1) begin bad++; $display("FAIL good_latency: got %0d want 1", bstart_q[s0] - last_tx_cyc); end
    end
    if (blen_q.size() > 0) begin
      total++; if (blen_q[blen_q.size()-1] != 4) begin bad++; $display("FAIL good_run_len: got %0d want 4", blen_q[blen_q.size()-1]); end
    end
    for (int i = 0; i < 4; i++) begin
      got = (b0 + i < cap_q.size()) ? cap_q[b0+i] : 8'hxx;
      total++; if (got !== GOOD_B[i]) begin bad++; $display("FAIL good_beat%0d: got %h want %h", i, got, GOOD_B[i]); end
    end
    total++; if (ok_cnt - k0 != 1) begin bad++; $display("FAIL good_frame_ok: got %0d want 1", ok_cnt - k0); end
    total++; if (errp_cnt != e0) begin bad++; $display("FAIL good_no_err: got %0d want %0d", errp_cnt, e0); end
    total++; if (bus.err_cnt !== 8'd0) begin bad++; $display("FAIL good_err_cnt: got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_bad_hcs();
    int b0, e0;
    logic [7:0] got;
    b0 = cap_q.size(); e0 = errp_cnt;
    load_good(); frm[5] = 8'h0B;
    send_range(0, 5);
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL hcs_frame_err: got %b want 1", bus.frame_err); end
    total++; if (bus.err_code !== 2'd1) begin bad++; $display("FAIL hcs_err_code: got %0d want 1", bus.err_code); end
    total++; if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL hcs_err_cnt: got %0d want 1", bus.err_cnt); end
    send_range(6, 8); tick(5);
    total++; if (errp_cnt - e0 != 1) begin bad++; $display("FAIL hcs_err_pulse: got %0d want 1", errp_cnt - e0); end
    total++; if (cap_q.size() != b0) begin bad++; $display("FAIL hcs_no_burst: got %0d want 0", cap_q.size() - b0); end
    load_good(); send_range(0, 8); tick(10);
    for (int i = 0; i < 4; i++) begin
      got = (b0 + i < cap_q.size()) ? cap_q[b0+i] : 8'hxx;
      total++; if (got !== GOOD_B[i]) begin bad++; $display("FAIL hcs_next_beat%0d: got %h want %h", i, got, GOOD_B[i]); end
    end
  endtask

  task automatic test_bad_len();
    int b0, e0;
    b0 = cap_q.size(); e0 = errp_cnt;
    frm[0] = 8'h5E; frm[1] = 8'h4D; frm[2] = 8'h0C; frm[3] = 8'h00; frm[4] = 8'h41; frm[5] = 8'h4D;
    send_range(0, 5);
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL len65_frame_err: got %b want 1", bus.frame_err); end
    total++; if (bus.err_code !== 2'd2) begin bad++; $display("FAIL len65_err_code: got %0d want 2", bus.err_code); end
    total++; if (bus.err_cnt !== 8'd2) begin bad++; $display("FAIL len65_err_cnt: got %0d want 2", bus.err_cnt); end
    for (int i = 0; i < 10; i++) send_byte(8'(8'h11 + i));
    tick(5);
    total++; if (errp_cnt - e0 != 1) begin bad++; $display("FAIL len65_ignored: got %0d want 1", errp_cnt - e0); end
    total++; if (cap_q.size() != b0) begin bad++; $display("FAIL len65_no_burst: got %0d want 0", cap_q.size() - b0); end
  endtask

  task automatic test_bad_dcs();
    int b0;
    logic [7:0] got;
    logic [7:0] e [5];
    e = '{8'h00, 8'h0A, 8'h06, 8'h00, 8'h00};
    b0 = cap_q.size();
    frm[0] = 8'h5E; frm[1] = 8'h4D; frm[2] = 8'h0A; frm[3] = 8'h00; frm[4] = 8'h03; frm[5] = 8'h09;
    frm[6] = 8'h06; frm[7] = 8'h00; frm[8] = 8'h00; frm[9] = 8'h07;
    send_range(0, 9);
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL dcs_frame_err: got %b want 1", bus.frame_err); end
    total++; if (bus.err_code !== 2'd3) begin bad++; $display("FAIL dcs_err_code: got %0d want 3", bus.err_code); end
    total++; if (bus.err_cnt !== 8'd3) begin bad++; $display("FAIL dcs_err_cnt: got %0d want 3", bus.err_cnt); end
    tick(5);
    total++; if (cap_q.size() != b0) begin bad++; $display("FAIL dcs_no_burst: got %0d want 0", cap_q.size() - b0); end
    frm[9] = 8'h06; send_range(0, 9); tick(10);
    total++; if (cap_q.size() - b0 != 5) begin bad++; $display("FAIL dcs_resend_len: got %0d want 5", cap_q.size() - b0); end
    for (int i = 0; i < 5; i++) begin
      got = (b0 + i < cap_q.size()) ? cap_q[b0+i] : 8'hxx;
      total++; if (got !== e[i]) begin bad++; $display("FAIL dcs_resend_beat%0d: got %h want %h", i, got, e[i]); end
    end
  endtask

  task automatic test_len_bounds();
    int b0;
    logic [7:0] got, dcs;
    frm[0] = 8'h5E; frm[1] = 8'h4D; frm[2] = 8'h01; frm[3] = 8'h02; frm[4] = 8'h00; frm[5] = 8'h03;
    send_range(0, 5);
    total++; if (bus.err_code !== 2'd2) begin bad++; $display("FAIL len0_err_code: got %0d want 2", bus.err_code); end
    total++; if (bus.err_cnt !== 8'd4) begin bad++; $display("FAIL len0_err_cnt: got %0d want 4", bus.err_cnt); end
    b0 = cap_q.size();
    frm[4] = 8'h01; frm[5] = 8'h02; frm[6] = 8'hAA; frm[7] = 8'hAA;
    send_range(0, 7); tick(8);
    total++; if (cap_q.size() - b0 != 3) begin bad++; $display("FAIL len1_burst_len: got %0d want 3", cap_q.size() - b0); end
    got = (b0 + 2 < cap_q.size()) ? cap_q[b0+2] : 8'hxx;
    total++; if (got !== 8'hAA) begin bad++; $display("FAIL len1_payload: got %h want aa", got); end
    b0 = cap_q.size(); dcs = 8'h00;
    frm[2] = 8'h20; frm[3] = 8'h01; frm[4] = 8'h40; frm[5] = 8'h61;
    for (int i = 0; i < 64; i++) begin
      frm[6+i] = 8'(i * 7 + 3);
      dcs = dcs ^ frm[6+i];
    end
    frm[70] = dcs;
    send_range(0, 70); tick(75);
    total++; if (cap_q.size() - b0 != 66) begin bad++; $display("FAIL len64_burst_len: got %0d want 66", cap_q.size() - b0); end
    got = (b0 + 1 < cap_q.size()) ? cap_q[b0+1] : 8'hxx;
    total++; if (got !== 8'h20) begin bad++; $display("FAIL len64_addr_beat: got %h want 20", got); end
    for (int i = 0; i < 64; i++) begin
      got = (b0 + 2 + i < cap_q.size()) ? cap_q[b0+2+i] : 8'hxx;
      total++; if (got !== frm[6+i]) begin bad++; $display("FAIL len64_beat%0d: got %h want %h", i + 2, got, frm[6+i]); end
    end
  endtask

  task automatic test_resync();
    int b0;
    logic [7:0] got;
    b0 = cap_q.size();
    frm[0] = 8'h5E;
    for (int i = 0; i < 9; i++) frm[i+1] = GOOD[i];
    send_range(0, 9); tick(10);
    total++; if (cap_q.size() - b0 != 4) begin bad++; $display("FAIL resync_len: got %0d want 4", cap_q.size() - b0); end
    for (int i = 0; i < 4; i++) begin
      got = (b0 + i < cap_q.size()) ? cap_q[b0+i] : 8'hxx;
      total++; if (got !== GOOD_B[i]) begin bad++; $display("FAIL resync_beat%0d: got %h want %h", i, got, GOOD_B[i]); end
    end
  endtask

  task automatic test_timeout();
    int e0, w, lat;
    e0 = errp_cnt; w = 0;
    load_good(); send_range(0, 4);
    while (!bus.frame_err && w < 300) begin tick(1); w++; end
    tick(1);
    total++; if (errp_cnt - e0 != 1) begin bad++; $display("FAIL tmo_pulse: got %0d want 1", errp_cnt - e0); end
    lat = err_cyc - last_tx_cyc;
    total++; if (lat < TIMEOUT_CYC + 1 || lat > TIMEOUT_CYC + 3) begin bad++; $display("FAIL tmo_latency: got %0d want %0d..%0d", lat, TIMEOUT_CYC + 1, TIMEOUT_CYC + 3); end
    total++; if (bus.err_code !== 2'd0) begin bad++; $display("FAIL tmo_err_code: got %0d want 0", bus.err_code); end
    total++; if (bus.err_cnt !== 8'd5) begin bad++; $display("FAIL tmo_err_cnt: got %0d want 5", bus.err_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    int b0, k0;
    logic [7:0] got;
    load_good(); send_range(0, 8);
    tick(2);
    total++; if (bus.d !== 8'h02 || bus.d_asserted !== 1'b1) begin bad++; $display("FAIL rst_pre_beat2: got d=%h da=%b want d=02 da=1", bus.d, bus.d_asserted); end
    k0 = ok_cnt;
    #2; n_rst = 1'b0; #1;
    total++; if (bus.d_asserted !== 1'b0) begin bad++; $display("FAIL rst_d_asserted: got %b want 0", bus.d_asserted); end
    total++; if (bus.d !== 8'h00) begin bad++; $display("FAIL rst_d: got %h want 00", bus.d); end
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL rst_rx_ready: got %b want 1", bus.rx_ready); end
    total++; if (bus.err_cnt !== 8'd0 || bus.err_code !== 2'd0) begin bad++; $display("FAIL rst_err: got cnt=%0d code=%0d want 0 0", bus.err_cnt, bus.err_code); end
    tick(2);
    @(negedge clk_ftdi); n_rst = 1'b1;
    tick(4);
    total++; if (ok_cnt != k0) begin bad++; $display("FAIL rst_no_frame_ok: got %0d want %0d", ok_cnt, k0); end
    b0 = cap_q.size();
    load_good(); send_range(0, 8); tick(10);
    for (int i = 0; i < 4; i++) begin
      got = (b0 + i < cap_q.size()) ? cap_q[b0+i] : 8'hxx;
      total++; if (got !== GOOD_B[i]) begin bad++; $display("FAIL rst_next_beat%0d: got %h want %h", i, got, GOOD_B[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int b0, s0, k0, e0, v0, l0, gap;
    logic [7:0] got;
    logic [7:0] e [9];
    e = '{8'h00, 8'h08, 8'h02, 8'h00, 8'h00, 8'h0A, 8'h06, 8'h00, 8'h00};
    b0 = cap_q.size(); s0 = bstart_q.size(); k0 = ok_cnt; e0 = errp_cnt; v0 = viol; l0 = low_q.size();
    load_good(); send_range(0, 8);
    drive_raw(8'h5E); drive_raw(8'h4D);
    frm[0] = 8'h5E; frm[1] = 8'h4D; frm[2] = 8'h0A; frm[3] = 8'h00; frm[4] = 8'h03; frm[5] = 8'h09;
    frm[6] = 8'h06; frm[7] = 8'h00; frm[8] = 8'h00; frm[9] = 8'h06;
    send_range(0, 9); tick(15);
    total++; if (bstart_q.size() - s0 != 2) begin bad++; $display("FAIL b2b_bursts: got %0d want 2", bstart_q.size() - s0); end
    for (int i = 0; i < 9; i++) begin
      got = (b0 + i < cap_q.size()) ? cap_q[b0+i] : 8'hxx;
      total++; if (got !== e[i]) begin bad++; $display("FAIL b2b_beat%0d: got %h want %h", i, got, e[i]); end
    end
    total++; if (ok_cnt - k0 != 2) begin bad++; $display("FAIL b2b_frame_ok: got %0d want 2", ok_cnt - k0); end
    total++; if (errp_cnt != e0) begin bad++; $display("FAIL b2b_no_err: got %0d want %0d", errp_cnt, e0); end
    total++; if (viol != v0) begin bad++; $display("FAIL b2b_ready_in_burst: got %0d want 0", viol - v0); end
    if (low_q.size() - l0 >= 2) begin
      total++; if (low_q[l0] != 6) begin bad++; $display("FAIL b2b_busy1: got %0d want 6", low_q[l0]); end
      total++; if (low_q[l0+1] != 7) begin bad++; $display("FAIL b2b_busy2: got %0d want 7", low_q[l0+1]); end
    end else begin
      total++; bad++; $display("FAIL b2b_busy_windows: got %0d want 2", low_q.size() - l0);
    end
    if (bstart_q.size() - s0 >= 2) begin
      gap = bstart_q[s0+1] - (bstart_q[s0] + 4);
      total++; if (gap < GAP_CYC) begin bad++; $display("FAIL b2b_gap: got %0d want >=%0d", gap, GAP_CYC); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_hcs();
    test_bad_len();
    test_bad_dcs();
    test_len_bounds();
    test_resync();
    test_timeout();
    test_reset_mid_burst();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
